// File: rtl/matrix_loader_param.sv
// Deserialises a dibit stream into two DIM x DIM matrices (A then B) and serves one A row / one B column per cycle.
// Define MATRIX_LOADER_CHECKSUM_EN to require a trailing XOR checksum element after B.

module matrix_loader_param #(
    parameter int DIM    = 32,
    parameter int ELEM_W = 8,
    parameter int IDX_W  = $clog2(DIM)
) (
    input  logic                  eth_refclk,
    input  logic                  rst_n,
    input  logic                  axiiv,
    input  logic [1:0]            axiid,
    input  logic [IDX_W-1:0]      requested_a_row,
    input  logic [IDX_W-1:0]      requested_b_col,
    output logic [IDX_W-1:0]      addr_out,
    output logic [DIM*ELEM_W-1:0] a_row_out,
    output logic [DIM*ELEM_W-1:0] b_col_out,
    output logic                  complete,
    output logic                  error
);

    localparam int DIBITS = ELEM_W / 2;
    localparam int CNT_W  = (DIBITS > 1) ? $clog2(DIBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIBIT = CNT_W'(DIBITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
`ifdef MATRIX_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        DRAIN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     dibit_cnt;
    logic [IDX_W-1:0]     row;
    logic [IDX_W-1:0]     col;
    logic [ELEM_W-1:0]    sr;
    logic [ELEM_W-1:0]    new_elem;
    logic                 consume;
    logic                 elem_done;
    logic                 in_matrix;
    logic                 last_elem;
    logic                 wr_a;
    logic                 wr_b;
    logic                 abort;
    logic [DIM*ELEM_W-1:0] a_row_nxt;
    logic [DIM*ELEM_W-1:0] b_col_nxt;

    logic [ELEM_W-1:0] mem_a [DIM][DIM];
    logic [ELEM_W-1:0] mem_b [DIM][DIM];

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [ELEM_W-1:0] acc;
    logic [ELEM_W-1:0] acc_nxt;
`endif

    // LSB-first assembly: each new dibit enters at the top, so the first one ends at [1:0].
    always_comb begin
        new_elem = sr >> 2;
        new_elem[ELEM_W-1 -: 2] = axiid;
    end

    // IDLE and DRAIN consume the first dibit of a new frame on the edge they leave.
    assign consume   = axiiv && (state != DONE);
    assign elem_done = consume && (dibit_cnt == LAST_DIBIT);
    assign in_matrix = (state == IDLE) || (state == DRAIN) || (state == LOAD_A) || (state == LOAD_B);
    assign last_elem = (row == LAST_IDX) && (col == LAST_IDX);
    assign wr_a      = elem_done && ((state == IDLE) || (state == DRAIN) || (state == LOAD_A));
    assign wr_b      = elem_done && (state == LOAD_B);
`ifdef MATRIX_LOADER_CHECKSUM_EN
    assign abort     = !axiiv && ((state == LOAD_A) || (state == LOAD_B) || (state == CHECK));
    assign acc_nxt   = (((state == IDLE) || (state == DRAIN)) ? '0 : acc)
                     ^ ((elem_done && in_matrix) ? new_elem : '0);
`else
    assign abort     = !axiiv && ((state == LOAD_A) || (state == LOAD_B));
`endif

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dibit_cnt <= '0;
            row       <= '0;
            col       <= '0;
            sr        <= '0;
            complete  <= 1'b0;
            error     <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            // NOTE: every flop here uses <= so each sees its neighbours' pre-edge values.
            error <= 1'b0;
            if (consume) begin
                sr        <= new_elem;
                dibit_cnt <= (dibit_cnt == LAST_DIBIT) ? '0 : dibit_cnt + CNT_W'(1);
`ifdef MATRIX_LOADER_CHECKSUM_EN
                acc       <= acc_nxt;
`endif
            end
            if (elem_done && in_matrix) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= (row == LAST_IDX) ? '0 : row + IDX_W'(1);
                end else begin
                    col <= col + IDX_W'(1);
                end
            end

            if (abort) begin
                state     <= IDLE;
                error     <= 1'b1;
                complete  <= 1'b0;
                dibit_cnt <= '0;
                row       <= '0;
                col       <= '0;
            end else begin
                case (state)
                    IDLE, DRAIN: begin
                        if (axiiv) begin
                            state    <= LOAD_A;
                            complete <= 1'b0;
                        end
                    end
                    LOAD_A: begin
                        if (elem_done && last_elem) state <= LOAD_B;
                    end
                    LOAD_B: begin
                        if (elem_done && last_elem) begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= DONE;
                            complete <= 1'b1;
`endif
                        end
                    end
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (elem_done) begin
                            if (new_elem == acc) begin
                                state    <= DONE;
                                complete <= 1'b1;
                            end else begin
                                state    <= DRAIN;
                                error    <= 1'b1;
                            end
                        end
                    end
`endif
                    DONE: begin
                        if (!axiiv) state <= DRAIN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is cleared on reset so reads return zero; this keeps it in flops rather than RAM.
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    mem_a[i][j] <= '0;
                    mem_b[i][j] <= '0;
                end
            end
        end else begin
            if (wr_a) mem_a[row][col] <= new_elem;
            if (wr_b) mem_b[row][col] <= new_elem;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both vectors and no latch is inferred.
        a_row_nxt = '0;
        b_col_nxt = '0;
        if (int'(requested_a_row) < DIM) begin
            for (int j = 0; j < DIM; j++) a_row_nxt[j*ELEM_W +: ELEM_W] = mem_a[requested_a_row][j];
        end
        if (int'(requested_b_col) < DIM) begin
            for (int i = 0; i < DIM; i++) b_col_nxt[i*ELEM_W +: ELEM_W] = mem_b[i][requested_b_col];
        end
    end

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out  <= '0;
            a_row_out <= '0;
            b_col_out <= '0;
        end else begin
            addr_out  <= requested_a_row;
            a_row_out <= a_row_nxt;
            b_col_out <= b_col_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_loader_param.sv
// Bench for matrix_loader_param: a 4x4/4-bit instance checked every cycle against an array model,
// plus a 32x32/8-bit instance for the diagonal and 100-dibit abort scenarios.

module tb_matrix_loader_param;

    localparam int MD = 4;
    localparam int MW = 4;
    localparam int MI = 2;
    localparam int FRAME_DIBITS = MD * MD * MW;
    localparam int BD = 32;
    localparam int BW = 8;
    localparam int BI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              axiiv = 1'b0;
    logic [1:0]        axiid = '0;
    logic [MI-1:0]     requested_a_row = '0;
    logic [MI-1:0]     requested_b_col = '0;
    logic [MI-1:0]     addr_out;
    logic [MD*MW-1:0]  a_row_out;
    logic [MD*MW-1:0]  b_col_out;
    logic              complete;
    logic              error;

    logic              axiiv_w = 1'b0;
    logic [1:0]        axiid_w = '0;
    logic [BI-1:0]     big_row = '0;
    logic [BI-1:0]     big_col = '0;
    logic [BI-1:0]     addr_w;
    logic [BD*BW-1:0]  a_row_w;
    logic [BD*BW-1:0]  b_col_w;
    logic              complete_w;
    logic              error_w;

    matrix_loader_param #(.DIM(MD), .ELEM_W(MW)) dut (
        .eth_refclk      (clk),
        .rst_n           (rst_n),
        .axiiv           (axiiv),
        .axiid           (axiid),
        .requested_a_row (requested_a_row),
        .requested_b_col (requested_b_col),
        .addr_out        (addr_out),
        .a_row_out       (a_row_out),
        .b_col_out       (b_col_out),
        .complete        (complete),
        .error           (error)
    );

    matrix_loader_param #(.DIM(BD), .ELEM_W(BW)) dut_big (
        .eth_refclk      (clk),
        .rst_n           (rst_n),
        .axiiv           (axiiv_w),
        .axiid           (axiid_w),
        .requested_a_row (big_row),
        .requested_b_col (big_col),
        .addr_out        (addr_w),
        .a_row_out       (a_row_w),
        .b_col_out       (b_col_w),
        .complete        (complete_w),
        .error           (error_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what storage holds and what the status flags must read.
    logic [MW-1:0] ref_a [MD][MD];
    logic [MW-1:0] ref_b [MD][MD];
    logic [MW-1:0] frame_a [MD][MD];
    logic [MW-1:0] frame_b [MD][MD];
    logic          exp_complete = 1'b0;
    logic          exp_error = 1'b0;
    logic          rand_req = 1'b1;

    logic             pend_valid = 1'b0;
    logic [MI-1:0]    pend_addr;
    logic [MD*MW-1:0] pend_a;
    logic [MD*MW-1:0] pend_b;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_error = 1'b0;
        if (rand_req) begin
            requested_a_row = MI'($urandom);
            requested_b_col = MI'($urandom);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                ref_a[i][j] = '0;
                ref_b[i][j] = '0;
            end
        end
        exp_complete = 1'b0;
        exp_error    = 1'b0;
    endtask

    task automatic do_abort();
        axiiv = 1'b0;
        tick();
        exp_error    = 1'b1;
        exp_complete = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_addr", addr_out, '0);
        check("rst_a_row", a_row_out, '0);
        check("rst_b_col", b_col_out, '0);
        check("rst_complete", complete, '0);
        check("rst_error", error, '0);
        check("rst_big_complete", complete_w, '0);
        clear_model();
        axiiv = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                frame_a[i][j] = MW'($urandom);
                frame_b[i][j] = MW'($urandom);
            end
        end
    endtask

    // Sends one frame element by element; optional abort or reset after a given dibit count.
    task automatic send_frame(input int abort_at, input int rst_at, input int extra, input bit bad_ck);
        int n;
        int r;
        int c;
        logic [MW-1:0] v;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        logic [MW-1:0] x;
        x = '0;
`endif
        n = 0;
        for (int e = 0; e < 2*MD*MD; e++) begin
            r = (e % (MD*MD)) / MD;
            c = e % MD;
            v = (e < MD*MD) ? frame_a[r][c] : frame_b[r][c];
`ifdef MATRIX_LOADER_CHECKSUM_EN
            x = x ^ v;
`endif
            for (int k = 0; k < MW/2; k++) begin
                if (n == abort_at) begin
                    do_abort();
                    return;
                end
                if (n == rst_at) begin
                    do_reset();
                    return;
                end
                axiiv = 1'b1;
                axiid = v[2*k +: 2];
                tick();
                n++;
                if (n == 1) exp_complete = 1'b0;
            end
            if (e < MD*MD) ref_a[r][c] = v;
            else           ref_b[r][c] = v;
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        v = x ^ MW'(bad_ck);
        for (int k = 0; k < MW/2; k++) begin
            axiiv = 1'b1;
            axiid = v[2*k +: 2];
            tick();
        end
        if (bad_ck) exp_error = 1'b1;
        else        exp_complete = 1'b1;
`else
        exp_complete = !bad_ck;
`endif
        repeat (extra) begin
            axiiv = 1'b1;
            axiid = 2'($urandom);
            tick();
        end
        axiiv = 1'b0;
        tick();
    endtask

    task automatic send_big(input bit diag, input int abort_at);
        int n;
        int r;
        int c;
        logic [BW-1:0] v;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        logic [BW-1:0] x;
        x = '0;
`endif
        n = 0;
        for (int e = 0; e < 2*BD*BD; e++) begin
            r = (e % (BD*BD)) / BD;
            c = e % BD;
            v = !diag ? 8'h5A : ((r == c) ? 8'h00 : 8'hFF);
`ifdef MATRIX_LOADER_CHECKSUM_EN
            x = x ^ v;
`endif
            for (int k = 0; k < BW/2; k++) begin
                if (n == abort_at) begin
                    axiiv_w = 1'b0;
                    tick();
                    check("big_abort_error", error_w, 1);
                    check("big_abort_complete", complete_w, 0);
                    tick();
                    check("big_error_one_cycle", error_w, 0);
                    return;
                end
                axiiv_w = 1'b1;
                axiid_w = v[2*k +: 2];
                tick();
                n++;
            end
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        for (int k = 0; k < BW/2; k++) begin
            axiiv_w = 1'b1;
            axiid_w = x[2*k +: 2];
            tick();
        end
`endif
        check("big_complete_rise", complete_w, 1);
        axiiv_w = 1'b0;
        tick();
        check("big_complete_hold", complete_w, 1);
    endtask

    // Per-cycle compare: data outputs against last cycle's prediction, flags against the model now.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                check("addr_out", addr_out, pend_addr);
                check("a_row_out", a_row_out, pend_a);
                check("b_col_out", b_col_out, pend_b);
            end
            check("complete", complete, exp_complete);
            check("error", error, exp_error);
            pend_addr = requested_a_row;
            for (int j = 0; j < MD; j++) begin
                pend_a[j*MW +: MW] = ref_a[requested_a_row][j];
                pend_b[j*MW +: MW] = ref_b[j][requested_b_col];
            end
            pend_valid = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BD*BW-1:0] exp_big;
        clear_model();
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("init_a_row", a_row_out, '0);
        check("init_b_col", b_col_out, '0);
        check("init_complete", complete, '0);
        tick();

        // Directed frame: A[i][j] = 4i+j, B[i][j] = 15-(4i+j).
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                frame_a[i][j] = MW'(i*MD + j);
                frame_b[i][j] = MW'(15 - (i*MD + j));
            end
        end
        send_frame(-1, -1, 0, 1'b0);
        rand_req = 1'b0;
        requested_a_row = 2'd1;
        requested_b_col = 2'd2;
        tick();
        check("lit_b_col2", b_col_out, 16'h159D);
        check("lit_a_row1", a_row_out, 16'h7654);
        check("lit_addr1", addr_out, 2'd1);
        check("lit_complete", complete, 1);
        requested_a_row = 2'd3;
        requested_b_col = 2'd0;
        tick();
        check("lit_a_row3", a_row_out, 16'hFEDC);
        check("lit_b_col0", b_col_out, 16'h37BF);
        rand_req = 1'b1;

        // Overrun, aborts (mid-element, at the A/B boundary, first dibit), reset mid-B.
        fill_random();
        send_frame(-1, -1, 20, 1'b0);
        fill_random();
        send_frame(31, -1, 0, 1'b0);
        fill_random();
        send_frame(32, -1, 0, 1'b0);
        fill_random();
        send_frame(1, -1, 0, 1'b0);
        fill_random();
        send_frame(-1, 40, 0, 1'b0);
        fill_random();
        send_frame(-1, -1, 0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            fill_random();
            if ($urandom_range(3, 0) == 0) send_frame(int'($urandom_range(FRAME_DIBITS - 1, 1)), -1, 0, 1'b0);
            else                           send_frame(-1, -1, int'($urandom_range(5, 0)), 1'b0);
            repeat ($urandom_range(2, 0)) tick();
        end

`ifdef MATRIX_LOADER_CHECKSUM_EN
        fill_random();
        send_frame(-1, -1, 0, 1'b1);
        check("cksum_bad_complete", complete, 0);
        fill_random();
        send_frame(-1, -1, 0, 1'b0);
        check("cksum_good_complete", complete, 1);
`endif

        // 32x32: abort after 100 dibits, then the diagonal frame.
        send_big(1'b0, 100);
        send_big(1'b1, -1);
        for (int j = 0; j < BD; j++) exp_big[j*BW +: BW] = (j == 5) ? 8'h00 : 8'hFF;
        big_row = 5'd5;
        big_col = 5'd5;
        tick();
        check("big_addr5", addr_w, 5'd5);
        check("big_a_row5", a_row_w, exp_big);
        check("big_b_col5", b_col_w, exp_big);
        for (int j = 0; j < BD; j++) exp_big[j*BW +: BW] = (j == 0) ? 8'h00 : 8'hFF;
        big_row = 5'd0;
        tick();
        check("big_a_row0", a_row_w, exp_big);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
